// File: rtl/dmem_frame_arbiter.sv
// dmem_frame_arbiter: shares a single data-memory port between the CPU and a
// once-per-frame fetch of a small object table into a double-buffered copy.
// The CPU always wins the port. The fetcher uses idle cycles, and CPU stores
// into the already-fetched part of the table are snooped into the back buffer.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_IDLE  | waiting for screen_end; port belongs to the CPU
// S_FETCH | issuing table reads on cycles where the CPU leaves the port idle
// S_DRAIN | last read in flight; capture it into the back buffer
// S_SWAP  | exchange front/back, pulse fetch_done, bump frame_count
module dmem_frame_arbiter #(
  parameter logic [11:0] BASE_ADDR = 12'd256,
  parameter int          NUM_WORDS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        screen_end,
  input  logic        cpu_mem_active,
  input  logic        cpu_wren,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_data,
  output logic        ram_wen,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic [3:0]  vga_sel,
  output logic [31:0] vga_word,
  output logic        frame_valid,
  output logic        fetch_done,
  output logic        overrun,
  output logic [7:0]  frame_count
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   pend_idx_q, pend_idx_d;
  logic            front_q, front_d;
  logic            frame_valid_q, frame_valid_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      frame_count_q, frame_count_d;

  // bank_q[front_q] is shown to VGA; the other bank is being filled.
  logic [31:0]     bank_q [2][NUM_WORDS];

  logic [11:0]     cpu_off;
  logic            snoop_hit;
  logic [IW-1:0]   snoop_idx;

  // Snoop: CPU stores to table words whose read was already issued this fetch
  // would otherwise be lost, so they are mirrored into the back buffer.
  always_comb begin
    cpu_off   = cpu_addr - BASE_ADDR;
    snoop_idx = cpu_off[IW-1:0];
    snoop_hit = cpu_mem_active && cpu_wren && (state_q != S_IDLE) &&
                (cpu_off < 12'(NUM_WORDS)) && (cpu_off < 12'(idx_q));
  end

  // Next-state, port arbitration and status outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pend_d        = 1'b0;
    pend_idx_d    = pend_idx_q;
    front_d       = front_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    fetch_done    = 1'b0;
    ram_wen       = 1'b0;
    ram_addr      = cpu_addr;
    ram_din       = cpu_data;

    if (screen_end && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (screen_end) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (!cpu_mem_active) begin
          ram_addr   = BASE_ADDR + 12'(idx_q);
          idx_d      = idx_q + 1'b1;
          pend_d     = 1'b1;
          pend_idx_d = idx_q[IW-1:0];
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_SWAP;
      end
      S_SWAP: begin
        fetch_done    = 1'b1;
        front_d       = ~front_q;
        frame_valid_d = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // CPU owns the port outright whenever it is active, reset included.
    if (cpu_mem_active) begin
      ram_wen  = cpu_wren;
      ram_addr = cpu_addr;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      front_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      pend_idx_q    <= pend_idx_d;
      front_q       <= front_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Back-buffer fill: read capture first, snooped CPU store overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          bank_q[b][w] <= 32'd0;
        end
      end
    end else begin
      if (pend_q) begin
        bank_q[~front_q][pend_idx_q] <= ram_dout;
      end
      if (snoop_hit) begin
        bank_q[~front_q][snoop_idx] <= cpu_data;
      end
    end
  end

  // VGA read port: front buffer only, out-of-range selects read as zero.
  always_comb begin
    vga_word = 32'd0;
    if ({1'b0, vga_sel} < 5'(NUM_WORDS)) begin
      vga_word = bank_q[front_q][vga_sel[IW-1:0]];
    end
  end

  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dmem_frame_arbiter.sv
// Directed bench for dmem_frame_arbiter with a behavioural synchronous RAM.
module tb_dmem_frame_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        screen_end;
  logic        cpu_mem_active;
  logic        cpu_wren;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [3:0]  vga_sel;
  logic [31:0] vga_word;
  logic        frame_valid, fetch_done, overrun;
  logic [7:0]  frame_count;

  logic        ram_wen8;
  logic [11:0] ram_addr8;
  logic [31:0] ram_din8;
  logic [31:0] ram_dout8;
  logic [31:0] vga_word8;
  logic        frame_valid8, fetch_done8, overrun8;
  logic [7:0]  frame_count8;

  logic        tb_we;
  logic [11:0] tb_waddr;
  logic [31:0] tb_wdata;
  logic [31:0] mem [4096];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  dmem_frame_arbiter u_dut (
    .clock(clock), .reset(reset), .screen_end(screen_end),
    .cpu_mem_active(cpu_mem_active), .cpu_wren(cpu_wren),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .vga_sel(vga_sel), .vga_word(vga_word),
    .frame_valid(frame_valid), .fetch_done(fetch_done),
    .overrun(overrun), .frame_count(frame_count)
  );

  dmem_frame_arbiter #(.BASE_ADDR(12'd256), .NUM_WORDS(8)) u_dut8 (
    .clock(clock), .reset(reset), .screen_end(screen_end),
    .cpu_mem_active(cpu_mem_active), .cpu_wren(cpu_wren),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ram_wen(ram_wen8), .ram_addr(ram_addr8), .ram_din(ram_din8),
    .ram_dout(ram_dout8), .vga_sel(vga_sel), .vga_word(vga_word8),
    .frame_valid(frame_valid8), .fetch_done(fetch_done8),
    .overrun(overrun8), .frame_count(frame_count8)
  );

  // Synchronous RAM: one-cycle read latency, bench-side preload port.
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    if (tb_we)   mem[tb_waddr] <= tb_wdata;
    ram_dout  <= mem[ram_addr];
    ram_dout8 <= mem[ram_addr8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_table(input int mode);
    for (int i = 0; i < 16; i++) begin
      tb_we    = 1'b1;
      tb_waddr = 12'(256 + i);
      tb_wdata = (mode == 0) ? 32'(i * 3) : 32'(32'h100 + i);
      tick();
    end
    tb_we = 1'b0;
    tick();
  endtask

  // Called in cycle 0; returns the cycle number in which fetch_done is seen.
  task automatic fetch_plain(output int done_cyc);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    done_cyc = 1;
    while (!fetch_done && done_cyc < 100) begin
      tick();
      done_cyc++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int cnt;
    int bad;
    logic done;
    logic [31:0] acc;

    reset = 1'b1; screen_end = 1'b0; cpu_mem_active = 1'b0; cpu_wren = 1'b0;
    cpu_addr = 12'd0; cpu_data = 32'd0; vga_sel = 4'd0;
    tb_we = 1'b0; tb_waddr = 12'd0; tb_wdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_fetch_done", fetch_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_count", frame_count, 0);
    vga_sel = 4'd5; #1;
    chk("rst_vga_word", vga_word, 0);

    // Uncontended fetch
    load_table(0);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    chk("t1_first_read_addr", ram_addr, 256);
    chk("t1_first_read_wen", ram_wen, 0);
    c = 1;
    while (!fetch_done && c < 100) begin
      tick();
      c++;
      if (c == 10) chk("t1_no_partial_front", vga_word, 0);
    end
    chk("t1_done_cycle", c, 18);
    tick();
    chk("t1_done_pulse", fetch_done, 0);
    vga_sel = 4'd5; #1;
    chk("t1_vga_sel5", vga_word, 15);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_n8_sel5", vga_word8, 15);
    vga_sel = 4'd10; #1;
    chk("t1_n8_sel_oor", vga_word8, 0);
    chk("t1_sel10", vga_word, 30);

    // Contention: CPU busy in cycles 3..6
    load_table(1);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    c = 1; done = 1'b0;
    while (c < 100 && !done) begin
      cpu_mem_active = (c >= 3 && c <= 6);
      cpu_wren = 1'b0;
      cpu_addr = 12'h040 + 12'(c);
      #1;
      if (cpu_mem_active) chk("t2_cpu_addr", ram_addr, 32'(12'h040 + 12'(c)));
      if (c == 7) chk("t2_resume_addr", ram_addr, 258);
      if (fetch_done) done = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    cpu_mem_active = 1'b0;
    chk("t2_done_cycle", c, 22);
    tick();
    for (int i = 0; i < 16; i++) begin
      vga_sel = 4'(i); #1;
      chk("t2_word", vga_word, 32'h100 + i);
    end
    chk("t2_frame_count", frame_count, 2);

    // Snoop: store to issued index 2, and to not-yet-issued index 14
    load_table(0);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    c = 1;
    while (!fetch_done && c < 100) begin
      cpu_mem_active = (c == 4 || c == 5);
      cpu_wren = cpu_mem_active;
      cpu_addr = (c == 4) ? 12'd258 : 12'd270;
      cpu_data = (c == 4) ? 32'hDEAD_BEEF : 32'h1234_5678;
      tick();
      c++;
    end
    cpu_mem_active = 1'b0; cpu_wren = 1'b0;
    chk("t3_done_cycle", c, 20);
    tick();
    vga_sel = 4'd2;  #1; chk("t3_snoop_sel2", vga_word, 32'hDEAD_BEEF);
    vga_sel = 4'd14; #1; chk("t3_late_sel14", vga_word, 32'h1234_5678);
    vga_sel = 4'd3;  #1; chk("t3_sel3", vga_word, 9);
    vga_sel = 4'd13; #1; chk("t3_sel13", vga_word, 39);

    // Overrun: second screen_end mid-fetch
    load_table(0);
    screen_end = 1'b1;
    tick();
    cnt = 0;
    for (int k = 1; k < 40; k++) begin
      screen_end = (k == 10);
      #1;
      if (k == 9) chk("t4_overrun_pre", overrun, 0);
      if (fetch_done) cnt++;
      tick();
    end
    screen_end = 1'b0;
    chk("t4_done_count", cnt, 1);
    chk("t4_overrun", overrun, 1);
    chk("t4_frame_count", frame_count, 4);

    // Reset mid-fetch at cycle 8, with screen_end and CPU store coincident
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    reset = 1'b1; screen_end = 1'b1;
    cpu_mem_active = 1'b1; cpu_wren = 1'b1;
    cpu_addr = 12'h7F0; cpu_data = 32'h0000_A5A5;
    #1;
    chk("t5_rst_pass_addr", ram_addr, 32'h7F0);
    chk("t5_rst_pass_wen", ram_wen, 1);
    chk("t5_rst_pass_din", ram_din, 32'h0000_A5A5);
    tick();
    reset = 1'b0; screen_end = 1'b0; cpu_mem_active = 1'b0; cpu_wren = 1'b0;
    chk("t5_frame_valid", frame_valid, 0);
    chk("t5_overrun", overrun, 0);
    chk("t5_frame_count", frame_count, 0);
    acc = 32'd0;
    for (int i = 0; i < 16; i++) begin
      vga_sel = 4'(i); #1;
      acc = acc | vga_word;
    end
    chk("t5_vga_all_zero", acc, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (fetch_done) cnt++;
      tick();
    end
    chk("t5_no_done", cnt, 0);
    fetch_plain(c);
    chk("t5_refetch_cycle", c, 18);
    tick();
    vga_sel = 4'd5; #1;
    chk("t5_refetch_sel5", vga_word, 15);
    chk("t5_refetch_count", frame_count, 1);

    // Wrap: 255 more frames brings the count to 256 -> 0
    bad = 0;
    for (int k = 0; k < 255; k++) begin
      fetch_plain(c);
      if (c != 18) bad++;
      tick();
    end
    chk("t6_all_latencies", bad, 0);
    chk("t6_frame_count_wrap", frame_count, 0);
    chk("t6_frame_valid", frame_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_frame_arbiter.md
DMEM_FRAME_ARBITER -- requirements
Module: dmem_frame_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'd256: first data-memory word of the per-frame object table.
REQ-002 SHALL have parameter NUM_WORDS, default 16: table length in words (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port screen_end  input  1  one-cycle pulse at end of each VGA frame (60 Hz).
REQ-006 SHALL have port cpu_mem_active  input  1  CPU drives a load or store to data memory this cycle.
REQ-007 SHALL have ports cpu_wren / cpu_addr / cpu_data  input  1/12/32  CPU write enable, word address, write data.
REQ-008 SHALL have ports ram_wen / ram_addr / ram_din  output  1/12/32  arbitrated data-memory port.
REQ-009 SHALL have port ram_dout  input  32  data-memory read data, valid the cycle after its address.
REQ-010 SHALL have port vga_sel  input  4  front-buffer word index requested by VGA logic.
REQ-011 SHALL have port vga_word  output  32  front-buffer word at vga_sel, combinational.
REQ-012 SHALL have ports frame_valid / fetch_done / overrun / frame_count  output  1/1/1/8  status.

Function
REQ-013 SHALL give the CPU absolute priority: when cpu_mem_active=1, ram_wen/ram_addr/ram_din equal cpu_wren/cpu_addr/cpu_data that cycle; the CPU is never stalled.
REQ-014 SHALL implement states IDLE, FETCH, DRAIN, SWAP.
REQ-015 IDLE: ram_wen=0, ram_addr=cpu_addr when CPU idle; screen_end=1 -> FETCH, index cleared.
REQ-016 FETCH: each cycle with cpu_mem_active=0, SHALL drive ram_wen=0, ram_addr=BASE_ADDR+index, then increment index and mark the read pending with its index.
REQ-017 A pending read SHALL be captured from ram_dout into back-buffer[pending index] on the next edge, regardless of cpu_mem_active that cycle.
REQ-018 After issuing index NUM_WORDS-1, SHALL move to DRAIN; DRAIN captures the last read, then -> SWAP.
REQ-019 SWAP (one cycle): front/back buffers exchange, fetch_done=1 for that cycle, frame_valid set to 1, frame_count+1 (8-bit wrap 255->0), then -> IDLE.
REQ-020 Uncontended latency: screen_end sampled at edge E0 -> reads issued cycles 1..NUM_WORDS, fetch_done high in cycle NUM_WORDS+2.
REQ-021 Each CPU-busy cycle in FETCH SHALL delay completion by exactly one cycle; no read is skipped or duplicated.
REQ-022 Snoop: a CPU store (cpu_mem_active=1, cpu_wren=1) to BASE_ADDR+i with i already issued in this fetch SHALL overwrite back-buffer[i] with cpu_data; if the same-edge capture targets i, the CPU data wins.
REQ-023 A CPU store to an index not yet issued SHALL not touch the back buffer (later read returns new data).
REQ-024 screen_end in FETCH, DRAIN or SWAP SHALL be ignored for fetching and SHALL set overrun=1 (sticky until reset).
REQ-025 vga_word SHALL read only the front buffer; it SHALL never show a partially fetched frame.
REQ-026 vga_sel >= NUM_WORDS SHALL return 32'd0.
REQ-027 fetch_done is a single-cycle pulse; frame_valid stays high once set.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, index=0, no pending read, both buffers all-zero, frame_valid=0, fetch_done=0, overrun=0, frame_count=0, and abort any fetch in progress.
REQ-029 During reset the CPU pass-through of REQ-013 SHALL remain combinationally active.
REQ-030 screen_end coincident with reset SHALL be ignored.

Verification
REQ-031 Uncontended: RAM[256+i]=i*3, screen_end pulse at cycle 0, cpu_mem_active=0 -> fetch_done in cycle 18, vga_word(sel=5)=15, frame_count=1.
REQ-032 Contention: cpu_mem_active=1 for cycles 3..6 during fetch -> ram_addr follows cpu_addr in those cycles, fetch_done in cycle 22, all 16 words correct.
REQ-033 Snoop: after index 2 issued, CPU stores 32'hDEAD_BEEF to 258 -> post-swap vga_word(sel=2)=32'hDEADBEEF; store to 270 before index 14 issued -> vga_word(sel=14) shows stored value.
REQ-034 Overrun: second screen_end at cycle 10 of a fetch -> overrun=1, single fetch_done, frame_count increments by 1 only.
REQ-035 Reset mid-fetch at cycle 8 -> next cycle IDLE, frame_valid=0, vga_word=0 for all sel, no fetch_done; next screen_end performs full fetch.
REQ-036 Wrap: 256 completed frames -> frame_count=0, frame_valid=1.
